// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite read/write channel bundle between a bus master and the SRAM responder.
interface axi_lite_sram_slave_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder in front of a word-addressed on-chip SRAM, one transaction
// at a time, with a fixed response latency to exercise master stall paths.
module axi_lite_sram_slave #(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int unsigned       LATENCY = 2
) (
    input logic                   clk,
    input logic                   rst,
    axi_lite_sram_slave_if.slave  bus
);
    localparam int unsigned       IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   SPAN        = (ADDR_W + 1)'(4 * DEPTH);
    localparam logic [3:0]        LAT         = 4'(LATENCY);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic [1:0]        r_bresp;
    logic [31:0]       r_mem [DEPTH];

    logic              w_idle;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_roff;
    logic [ADDR_W-1:0] w_woff;
    logic              w_rd_in;
    logic              w_wr_in;
    logic [IDX_W-1:0]  w_ridx;
    logic [IDX_W-1:0]  w_widx;

    // Accepts are masked during reset so nothing is taken in the reset cycle.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_rd_acc = w_idle && bus.arvalid;
    assign w_wr_acc = w_idle && bus.awvalid && bus.wvalid && !bus.arvalid;

    // Offset from BASE wraps for addresses below BASE, so a single unsigned
    // compare against the window size covers both range bounds.
    assign w_roff  = bus.araddr - BASE;
    assign w_woff  = bus.awaddr - BASE;
    assign w_rd_in = {1'b0, w_roff} < SPAN;
    assign w_wr_in = {1'b0, w_woff} < SPAN;
    assign w_ridx  = w_roff[IDX_W+1:2];
    assign w_widx  = w_woff[IDX_W+1:2];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and handshake outputs.
    always_comb begin
        w_next      = r_state;
        bus.arready = w_idle;
        bus.awready = w_wr_acc;
        bus.wready  = w_wr_acc;
        bus.rvalid  = (r_state == RD_RESP);
        bus.bvalid  = (r_state == WR_RESP);
        bus.rdata   = r_rdata;
        bus.rresp   = r_rresp;
        bus.bresp   = r_bresp;
        case (r_state)
            IDLE: begin
                if (w_rd_acc) begin
                    w_next = (LAT == 4'd0) ? RD_RESP : RD_WAIT;
                end else if (w_wr_acc) begin
                    w_next = (LAT == 4'd0) ? WR_RESP : WR_WAIT;
                end
            end
            RD_WAIT: if (r_cnt <= 4'd1) w_next = RD_RESP;
            RD_RESP: if (bus.rready)    w_next = IDLE;
            WR_WAIT: if (r_cnt <= 4'd1) w_next = WR_RESP;
            WR_RESP: if (bus.bready)    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rd_acc || w_wr_acc) begin
            r_cnt <= LAT;
        end else if (r_state == RD_WAIT || r_state == WR_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response payload captured at accept and held through the response phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_rd_acc) begin
                r_rdata <= w_rd_in ? r_mem[w_ridx] : '0;
                r_rresp <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_wr_acc) begin
                r_bresp <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // SRAM byte-lane write at accept; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && w_wr_in) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (bus.wstrb[k]) begin
                    r_mem[w_widx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench: transaction-level timing model plus directed and random traffic.
module tb_axi_lite_sram_slave;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned LAT    = 2;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_lite_sram_slave_if #(.ADDR_W(ADDR_W)) bus ();

    axi_lite_sram_slave #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: memory image with per-byte known flags, and the
    // outstanding transaction described by kind and response-due cycle.
    logic [31:0] m_mem   [DEPTH];
    logic [3:0]  m_known [DEPTH];
    logic        m_busy;
    logic        m_rd;
    int          m_at;
    logic [31:0] m_rdata;
    logic [3:0]  m_rmask;
    logic [1:0]  m_rresp;
    logic [1:0]  m_bresp;
    logic [31:0] pool [16];

    function automatic int cur_cyc();
        return int'($time / 10);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cur_cyc(), act, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] a, output bit inr, output int idx);
        longint a64;
        a64 = longint'(a);
        inr = (a64 >= longint'(BASE)) && (a64 < longint'(BASE) + longint'(4 * DEPTH));
        idx = inr ? int'((a64 - longint'(BASE)) / 4) : 0;
    endfunction

    // Compare and model-advance process: outputs checked every negedge, then the
    // model consumes the inputs that the coming posedge will sample.
    initial begin : model
        bit          inr;
        int          idx;
        int          c;
        logic        e_ar, e_aw, e_rv, e_bv;
        logic [31:0] bm;
        m_busy  = 1'b0;
        m_rd    = 1'b0;
        m_at    = 0;
        m_rdata = '0;
        m_rmask = 4'hF;
        m_rresp = 2'b00;
        m_bresp = 2'b00;
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 4'h0;
        forever begin
            @(negedge clk);
            c    = cur_cyc();
            e_rv = m_busy && m_rd && (c >= m_at);
            e_bv = m_busy && !m_rd && (c >= m_at);
            e_ar = !m_busy && !rst;
            e_aw = e_ar && bus.awvalid && bus.wvalid && !bus.arvalid;
            bm   = {{8{m_rmask[3]}}, {8{m_rmask[2]}}, {8{m_rmask[1]}}, {8{m_rmask[0]}}};
            check("arready", 32'(bus.arready), 32'(e_ar));
            check("awready", 32'(bus.awready), 32'(e_aw));
            check("wready",  32'(bus.wready),  32'(e_aw));
            check("rvalid",  32'(bus.rvalid),  32'(e_rv));
            check("bvalid",  32'(bus.bvalid),  32'(e_bv));
            check("rdata",   bus.rdata & bm,   m_rdata & bm);
            check("rresp",   32'(bus.rresp),   32'(m_rresp));
            check("bresp",   32'(bus.bresp),   32'(m_bresp));
            if (rst) begin
                m_busy  = 1'b0;
                m_rdata = '0;
                m_rmask = 4'hF;
                m_rresp = 2'b00;
                m_bresp = 2'b00;
            end else if (!m_busy) begin
                if (bus.arvalid) begin
                    decode(bus.araddr, inr, idx);
                    m_rdata = inr ? m_mem[idx] : 32'h0;
                    m_rmask = inr ? m_known[idx] : 4'hF;
                    m_rresp = inr ? 2'b00 : 2'b10;
                    m_busy  = 1'b1;
                    m_rd    = 1'b1;
                    m_at    = c + 1 + int'(LAT);
                end else if (bus.awvalid && bus.wvalid) begin
                    decode(bus.awaddr, inr, idx);
                    if (inr) begin
                        for (int k = 0; k < 4; k++) begin
                            if (bus.wstrb[k]) begin
                                m_mem[idx][8*k +: 8] = bus.wdata[8*k +: 8];
                                m_known[idx][k] = 1'b1;
                            end
                        end
                    end
                    m_bresp = inr ? 2'b00 : 2'b10;
                    m_busy  = 1'b1;
                    m_rd    = 1'b0;
                    m_at    = c + 1 + int'(LAT);
                end
            end else if (e_rv && bus.rready) begin
                m_busy = 1'b0;
            end else if (e_bv && bus.bready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Driver tasks: all are entered and left 1 time unit after a posedge.
    task automatic wait_r(input int stall, output logic [31:0] d, output logic [1:0] r, output int rsp);
        bit ok;
        int seen;
        ok = 1'b0; seen = 0; rsp = 0; d = '0; r = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            bus.rready = (stall < 0) ? 1'($urandom_range(0, 1)) : (seen >= stall);
            @(negedge clk);
            if (bus.rvalid) begin
                if (rsp == 0) rsp = cur_cyc();
                if (bus.rready) begin
                    ok = 1'b1; d = bus.rdata; r = bus.rresp;
                end else begin
                    seen++;
                end
            end
            @(posedge clk); #1;
        end
        bus.rready = 1'b0;
        check("r_handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_b(input int stall, output logic [1:0] r, output int rsp);
        bit ok;
        int seen;
        ok = 1'b0; seen = 0; rsp = 0; r = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            bus.bready = (stall < 0) ? 1'($urandom_range(0, 1)) : (seen >= stall);
            @(negedge clk);
            if (bus.bvalid) begin
                if (rsp == 0) rsp = cur_cyc();
                if (bus.bready) begin
                    ok = 1'b1; r = bus.bresp;
                end else begin
                    seen++;
                end
            end
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
        check("b_handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, input int stall, output logic [31:0] d,
                      output logic [1:0] r, output int acc, output int rsp);
        bit ok;
        ok = 1'b0; acc = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.arready) begin ok = 1'b1; acc = cur_cyc(); end
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0;
        check("ar_accept_timeout", 32'(ok), 32'd1);
        wait_r(stall, d, r, rsp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lone, input int stall, output logic [1:0] r,
                      output int acc, output int rsp);
        bit ok;
        ok = 1'b0; acc = 0;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        if (lone > 0) begin
            if ($urandom_range(0, 1) == 1) bus.awvalid = 1'b1;
            else                           bus.wvalid  = 1'b1;
            repeat (lone) begin @(posedge clk); #1; end
        end
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.awready) begin ok = 1'b1; acc = cur_cyc(); end
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_accept_timeout", 32'(ok), 32'd1);
        wait_b(stall, r, rsp);
    endtask

    // Starts a transaction, leaves the response unacknowledged and pulses reset
    // dly cycles after the cycle following the accept.
    task automatic rst_inject(input bit is_rd, input logic [31:0] a, input int dly);
        bit ok;
        ok = 1'b0;
        if (is_rd) begin
            bus.araddr = a; bus.arvalid = 1'b1;
        end else begin
            bus.awaddr = a; bus.wdata = $urandom; bus.wstrb = 4'($urandom);
            bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        end
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (is_rd ? bus.arready : bus.awready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("inject_accept_timeout", 32'(ok), 32'd1);
        repeat (dly) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 3))
                   0: a = BASE - 32'd4;
                   1: a = BASE + 32'(4 * DEPTH);
                   2: a = 32'h0000_0000;
                   default: a = 32'hFFFF_FFFC;
               endcase
            default: a = pool[$urandom_range(0, 15)];
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    function automatic int pick_stall();
        return ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 3));
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        logic [1:0]  r;
        int          acc, rsp, c;
        int          ar_c, r_c, aw_c, b_c;
        logic [31:0] cd;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_arready", 32'(bus.arready), 32'd0);
        check("reset_rvalid",  32'(bus.rvalid),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full write then readback, with response latency pinned.
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, acc, rsp);
        check("wr1_bresp", 32'(r), 32'd0);
        check("wr1_latency", 32'(rsp - acc), 32'(LAT + 1));
        rd(32'h8000_0010, 0, d, r, acc, rsp);
        check("rd1_rdata", d, 32'hDEAD_BEEF);
        check("rd1_rresp", 32'(r), 32'd0);
        check("rd1_latency", 32'(rsp - acc), 32'(LAT + 1));

        // Partial byte-lane write.
        wr(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, r, acc, rsp);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 1, r, acc, rsp);
        rd(32'h8000_0020, 0, d, r, acc, rsp);
        check("partial_rdata", d, 32'h11BB_33DD);

        // Empty strobe leaves memory untouched but still responds OKAY.
        wr(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 0, r, acc, rsp);
        check("nostrb_bresp", 32'(r), 32'd0);
        rd(32'h8000_0020, 0, d, r, acc, rsp);
        check("nostrb_rdata", d, 32'h11BB_33DD);

        // Out-of-range accesses.
        wr(BASE, 32'h0, 4'hF, 0, 0, r, acc, rsp);
        rd(32'h7FFF_FFFC, 0, d, r, acc, rsp);
        check("oor_rd_rresp", 32'(r), 32'd2);
        check("oor_rd_rdata", d, 32'h0);
        wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, r, acc, rsp);
        check("oor_wr_bresp", 32'(r), 32'd2);
        rd(BASE, 0, d, r, acc, rsp);
        check("oor_word0_kept", d, 32'h0);
        rd(32'h8000_3FFC, 0, d, r, acc, rsp);
        check("last_word_rresp", 32'(r), 32'd0);

        // Backpressure: rready low for 10 cycles of rvalid.
        rd(32'h8000_0010, 10, d, r, acc, rsp);
        check("stall_rdata", d, 32'hDEAD_BEEF);

        // Read and write contend in the same idle cycle.
        bus.araddr = BASE; bus.awaddr = BASE;
        bus.wdata  = 32'hCAFE_F00D; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.rready = 1'b1; bus.bready = 1'b1;
        ar_c = 0; r_c = 0; aw_c = 0; b_c = 0; cd = 32'hFFFF_FFFF;
        for (int i = 0; i < 60 && b_c == 0; i++) begin
            @(negedge clk);
            c = cur_cyc();
            if (bus.arvalid && bus.arready) ar_c = c;
            if (bus.awvalid && bus.awready) aw_c = c;
            if (bus.rvalid && bus.rready) begin r_c = c; cd = bus.rdata; end
            if (bus.bvalid && bus.bready) b_c = c;
            @(posedge clk); #1;
            if (ar_c != 0) bus.arvalid = 1'b0;
            if (aw_c != 0) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
        end
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.rready = 1'b0; bus.bready = 1'b0;
        check("cont_rdata_old", cd, 32'h0);
        check("cont_read_first", 32'(ar_c != 0 && r_c != 0 && ar_c < aw_c), 32'd1);
        check("cont_aw_after_r", 32'(aw_c - r_c), 32'd1);
        check("cont_b_done", 32'(b_c != 0), 32'd1);
        rd(BASE, 0, d, r, acc, rsp);
        check("cont_followup", d, 32'hCAFE_F00D);

        // Reset two cycles after a read accept.
        rst_inject(1'b1, 32'h8000_0010, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_rd_no_rvalid", 32'(bus.rvalid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_rd_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1;
        rd(32'h8000_0010, 0, d, r, acc, rsp);
        check("rst_mem_intact", d, 32'hDEAD_BEEF);

        // Random traffic over a small address pool.
        pool[0] = BASE;
        pool[1] = BASE + 32'h4;
        pool[2] = BASE + 32'(4 * (DEPTH - 1));
        pool[3] = BASE + 32'h10;
        for (int i = 4; i < 16; i++) pool[i] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        for (int i = 0; i < 16; i++) wr(pool[i], $urandom, 4'hF, 0, 0, r, acc, rsp);
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 99) < 55) begin
                rd(pick_addr(), pick_stall(), d, r, acc, rsp);
            end else begin
                wr(pick_addr(), $urandom, 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   pick_stall(), r, acc, rsp);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
        end

        // Random resets at various points of a transaction.
        for (int n = 0; n < 20; n++) begin
            rst_inject(1'($urandom_range(0, 1)), pick_addr(), int'($urandom_range(0, 4)));
            rd(pool[$urandom_range(0, 15)], 0, d, r, acc, rsp);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder backing an on-chip word-addressed SRAM.
- Serves the fetch unit's read requests (valid/ready handshake) and the memory stage's loads/stores.
- Adds a configurable response latency so the multicycle core's handshake paths are exercised with stalls.
- Handles one transaction at a time. Reads win over writes when both are pending.

Parameters:
- ADDR_W, 32, byte address width.
- DEPTH, 4096, SRAM size in 32-bit words (power of two).
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, idle cycles between request handshake and response valid (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte write strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: FSM=IDLE, counter=0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. SRAM contents are NOT reset and survive rst.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- arready = (state==IDLE). Combinational from state; 0 during the reset cycle.
- awready = wready = (state==IDLE) & awvalid & wvalid & ~arvalid.
  - AW and W are accepted only together, in the same cycle.
  - A lone awvalid or lone wvalid is held off, and the master must keep it asserted.
- Address decode:
  - idx = (addr - BASE) >> 2. The low 2 bits are ignored.
  - In range iff BASE <= addr < BASE + 4*DEPTH.
- Read accept (IDLE, arvalid), cycle T:
  - Latch rdata = in range ? mem[idx] : 32'h0, and rresp = in range ? 00 : 10.
  - Load counter = LATENCY.
  - Go to RD_WAIT, or straight to RD_RESP if LATENCY=0.
- RD_WAIT: decrement the counter each cycle. When it reaches 1, move to RD_RESP. rvalid rises exactly at cycle T+1+LATENCY.
- RD_RESP:
  - rvalid=1; rdata and rresp are held stable.
  - On rvalid & rready: rvalid drops the next cycle and the FSM returns to IDLE.
  - arready is 0 throughout, so there is no back-to-back accept in the same cycle as the response handshake.
- Write accept (IDLE, awvalid & wvalid & ~arvalid), cycle T:
  - If in range, commit at that edge: byte lane k written iff wstrb[k].
  - Out of range: no write, bresp=10.
  - Load counter and go through WR_WAIT to WR_RESP, with the same timing as reads. bvalid rises at T+1+LATENCY.
- WR_RESP: bvalid=1 until bready; then IDLE.
- Simultaneous arvalid and awvalid & wvalid in IDLE: the read is accepted; the write waits.
- Read-after-write to the same address returns the new data (the write is committed before any later read accept).
- wstrb=0000: OKAY response, memory unchanged.
- Reset mid-transaction:
  - Any pending response is dropped: rvalid and bvalid go low next cycle, FSM goes to IDLE.
  - A write already accepted stays committed.
- Master holding rready=0 or bready=0 indefinitely: the responder stalls in the RESP state with outputs stable. No timeout.

Test Plan:
- LATENCY=2: write awaddr=8000_0010, wdata=DEADBEEF, wstrb=1111, bready=1, accepted at cycle 5 -> bvalid high at cycle 8, bresp=00; then read 8000_0010 -> rdata=DEADBEEF, rresp=00.
- Partial write: mem word=11223344, write wdata=AABBCCDD, wstrb=0101 -> read returns 11BB33DD.
- Out of range: read 7FFF_FFFC -> rresp=10, rdata=0. Write 8000_4000 (DEPTH=4096) -> bresp=10; word 0 unchanged.
- Backpressure: rready held low for 10 cycles after rvalid -> rvalid and rdata stable for all 10 cycles; arready=0 until the cycle after the handshake.
- Contention: arvalid and awvalid&wvalid rise in the same IDLE cycle, read addr=write addr=8000_0000 (old value 0) -> read accepted first and returns 0; write accepted after R completes; a follow-up read returns the new data.
- Reset in RD_WAIT with LATENCY=5: rst pulsed 2 cycles after accept -> rvalid never asserts, FSM in IDLE, arready=1 after rst deasserts, prior memory contents intact.
